alu_logic_responder: RTL

//  Responder end of the integer-ALU logic-op request interface. Accepts operand

---
 rtl/alu_logic_responder_if.sv | 22 ++
 rtl/alu_logic_responder.sv | 59 +++++
 2 files changed

// File: rtl/alu_logic_responder_if.sv
// alu_logic_responder_if: request/response handshake bundle between ALU issue logic and the logic-op responder.
interface alu_logic_responder_if #(parameter int WIDTH = 4);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_x;
    logic [WIDTH-1:0] req_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_o;
    logic             rsp_zero;
    logic [7:0]       op_count;

    modport master (
        output req_valid, req_op, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_o, rsp_zero, op_count
    );
    modport slave (
        input  req_valid, req_op, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_o, rsp_zero, op_count
    );
endinterface

// File: rtl/alu_logic_responder.sv
// alu_logic_responder: computes bitwise XOR/AND/OR/XNOR per request and returns results through a small FIFO.
module alu_logic_responder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    alu_logic_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic [7:0]       ops;
    logic [WIDTH-1:0] result;
    logic             push, pop;

    always_comb begin
        result = bus.req_op == 2'b00 ? bus.req_x ^ bus.req_y :
                 bus.req_op == 2'b01 ? bus.req_x & bus.req_y :
                 bus.req_op == 2'b10 ? bus.req_x | bus.req_y :
                                       ~(bus.req_x ^ bus.req_y);
    end

    // Occupancy comes from cnt so full and empty never alias on equal pointers
    assign bus.req_ready = cnt != FULL_CNT;
    assign bus.rsp_valid = cnt != '0;
    assign push = bus.req_valid && bus.req_ready;
    assign pop  = bus.rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ops    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                ops    <= ops + 8'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= result;
    end

    // Storage is never reset; outputs are masked whenever the FIFO is empty
    assign bus.rsp_o    = bus.rsp_valid ? mem[rd_ptr] : '0;
    assign bus.rsp_zero = bus.rsp_valid && mem[rd_ptr] == '0;
    assign bus.op_count = ops;
endmodule
